countdown_timer: RTL and testbench

Down-counting mm:ss timer. It is the decrementing counterpart of the up-counting seconds/minutes chain, and consumes the same one-cycle tick strobe. The block is loaded with a start time, then decrements seconds on each tick and borrows from minutes on each seconds underflow. It pulses done when it reaches 00:00. It sits beside the clock chain, shares the 1 Hz tick source, and drives the same 6-bit display path.

---
 rtl/countdown_timer.sv | 72 +++++++
 tb/tb_countdown_timer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable mm:ss down-counter stepped by a one-cycle 1 Hz tick strobe.
// Borrows minutes on seconds underflow and pulses done on reaching 00:00.
module countdown_timer #(
  parameter logic [5:0] MAX_MIN = 6'd59,
  parameter logic [5:0] MAX_SEC = 6'd59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       borrow_out,
  output logic       done,
  output logic       expired,
  output logic       running
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
  state_t     state_q;
  logic [5:0] min_q, sec_q;
  logic       borrow_q, done_q;
  logic       is_zero, conflict;
  assign is_zero  = (min_q == 6'd0) && (sec_q == 6'd0);
  assign conflict = start && pause;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      min_q    <= 6'd0;
      sec_q    <= 6'd0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
      if (load) begin
        min_q   <= load_min > MAX_MIN ? MAX_MIN : load_min;
        sec_q   <= load_sec > MAX_SEC ? MAX_SEC : load_sec;
        state_q <= IDLE;
      end else if (start && !pause && state_q == IDLE) begin
        state_q <= is_zero ? DONE : RUN;
        done_q  <= is_zero;
      end else if (start && !pause && state_q == PAUSED) begin
        state_q <= RUN;
      end else if (pause && !start && state_q == RUN) begin
        state_q <= PAUSED;
      end else if (tick_in && !conflict && state_q == RUN) begin
        // RUN is only entered with a non-zero count, so a zero seconds field implies minutes > 0
        if (sec_q != 6'd0) begin
          sec_q <= sec_q - 6'd1;
          if (sec_q == 6'd1 && min_q == 6'd0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end else if (min_q != 6'd0) begin
          sec_q    <= MAX_SEC;
          min_q    <= min_q - 6'd1;
          borrow_q <= 1'b1;
        end
      end
    end
  end
  assign minutes    = min_q;
  assign seconds    = sec_q;
  assign borrow_out = borrow_q;
  assign done       = done_q;
  assign expired    = (state_q == DONE);
  assign running    = (state_q == RUN);
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: randomized + directed stimulus; a total-seconds reference model
// feeds an expectation queue that a separate monitor drains after every clock edge.
module tb_countdown_timer;
  localparam int MM = 59;
  localparam int MS = 59;
  localparam int BASE = MS + 1;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [5:0] load_min = 6'd0, load_sec = 6'd0;
  logic [5:0] minutes, seconds;
  logic       borrow_out, done, expired, running;
  typedef struct {
    int mn;
    int sc;
    bit bo;
    bit dn;
    bit ex;
    bit rn;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int rem = 0;
  bit m_run = 0, m_paused = 0, m_done = 0;
  countdown_timer dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
    .minutes(minutes), .seconds(seconds), .borrow_out(borrow_out),
    .done(done), .expired(expired), .running(running)
  );
  always #5 clk = ~clk;
  function automatic exp_t snapshot(bit bo, bit dn);
    exp_t e;
    e.mn = rem / BASE;
    e.sc = rem % BASE;
    e.bo = bo;
    e.dn = dn;
    e.ex = m_done;
    e.rn = m_run;
    return e;
  endfunction
  task automatic compare(string tag, exp_t e);
    checks++;
    if (int'(minutes) != e.mn || int'(seconds) != e.sc || borrow_out != e.bo ||
        done != e.dn || expired != e.ex || running != e.rn) begin
      errors++;
      $display("FAIL %s t=%0t: got %0d:%0d bo=%0b dn=%0b ex=%0b rn=%0b, want %0d:%0d bo=%0b dn=%0b ex=%0b rn=%0b",
               tag, $time, minutes, seconds, borrow_out, done, expired, running,
               e.mn, e.sc, e.bo, e.dn, e.ex, e.rn);
    end
  endtask
  // Reference behaviour for one clock edge, expressed on the remaining-seconds total
  task automatic model_edge();
    bit bo = 0, dn = 0;
    bit idle = !m_run && !m_paused && !m_done;
    if (reset) begin
      rem = 0; m_run = 0; m_paused = 0; m_done = 0;
    end else if (load) begin
      rem = (int'(load_min) > MM ? MM : int'(load_min)) * BASE + (int'(load_sec) > MS ? MS : int'(load_sec));
      m_run = 0; m_paused = 0; m_done = 0;
    end else if (start && !pause && idle) begin
      if (rem == 0) begin m_done = 1; dn = 1; end
      else m_run = 1;
    end else if (start && !pause && m_paused) begin
      m_paused = 0; m_run = 1;
    end else if (pause && !start && m_run) begin
      m_run = 0; m_paused = 1;
    end else if (tick_in && !(start && pause) && m_run) begin
      bo = (rem % BASE == 0);
      rem--;
      if (rem == 0) begin m_run = 0; m_done = 1; dn = 1; end
    end
    q.push_back(snapshot(bo, dn));
  endtask
  task automatic step(bit r, bit ld, int lm, int ls, bit st, bit ps, bit tk);
    @(negedge clk);
    reset = r; load = ld; load_min = 6'(lm); load_sec = 6'(ls);
    start = st; pause = ps; tick_in = tk;
    model_edge();
  endtask
  task automatic idle_cycles(int n, bit tk);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, tk);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) compare("edge", q.pop_front());
  end
  initial begin
    exp_t z;
    step(1, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    // load 01:02, start, 3 ticks with borrow on the third
    step(0, 1, 1, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin step(0, 0, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 0, 0, 0); end
    // 00:02 to DONE, then ticks and start are ignored
    step(0, 1, 0, 2, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    idle_cycles(3, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    idle_cycles(2, 1);
    // pause/resume with coincident ticks dropped
    step(0, 1, 0, 5, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    idle_cycles(4, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    // clamp, and start from 00:00
    step(0, 1, 63, 63, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    idle_cycles(2, 0);
    // load wins over a coincident tick while running
    step(0, 1, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 10, 1, 0, 1);
    idle_cycles(2, 1);
    // asynchronous reset between edges
    step(0, 1, 10, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    load = 0; start = 0; pause = 0; tick_in = 0;
    #2 reset = 1;
    #1;
    rem = 0; m_run = 0; m_paused = 0; m_done = 0;
    z = snapshot(0, 0);
    compare("async_reset", z);
    tick_in = 1;
    model_edge();
    step(0, 0, 0, 0, 0, 0, 1);
    idle_cycles(3, 1);
    // randomized traffic biased toward short counts so DONE is reached often
    for (int i = 0; i < 4000; i++) begin
      int r = $urandom_range(0, 99);
      bit ld = (r < 3);
      int lm = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 1);
      int ls = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 4);
      bit st = ($urandom_range(0, 99) < 8);
      bit ps = ($urandom_range(0, 99) < 4);
      bit tk = ($urandom_range(0, 99) < 60);
      bit rs = ($urandom_range(0, 999) == 0);
      step(rs, ld, lm, ls, st, ps, tk);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
